// File: rtl/sram_array_1p_clr_pkg.sv
// Shared definitions for the clearable single-port cache array: FSM encoding,
// address-width helper and the way-packing rule for wide data buses.
package sram_array_1p_clr_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } arr_state_e;

    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Way i of a packed WAYS*WIDTH bus lives at [way_lsb(i, WIDTH) +: WIDTH].
    function automatic int way_lsb(input int way, input int width);
        return way * width;
    endfunction

endpackage

// File: rtl/sram_array_1p_clr_bank.sv
// One way of the array: synchronous single-port memory, one-cycle read
// latency, contents and read register are not reset.
module bank_ram_1p #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 66,
    parameter int AW    = 6
) (
    input  logic             clock,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_array_1p_clr.sv
// Multi-way single-port cache array with a built-in clear engine that zeroes
// every entry after reset and on flush, and a held read response.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_CLEAR | writing zero to entry cnt of every way, requests blocked
//   ST_IDLE  | serving read/write requests, flush starts a new clear pass
module sram_array_1p_clr
    import sram_array_1p_clr_pkg::*;
#(
    parameter int  WAYS  = 1,
    parameter int  DEPTH = 64,
    parameter int  WIDTH = 66,
    localparam int AW    = log2_ceil(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_flush,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [AW-1:0]         io_req_addr,
    input  logic                  io_req_wen,
    input  logic [WAYS-1:0]       io_req_wmask,
    input  logic [WAYS*WIDTH-1:0] io_req_wdata,
    output logic                  io_resp_valid,
    output logic [WAYS*WIDTH-1:0] io_resp_rdata,
    output logic                  io_busy
);

    arr_state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic clr_active;
    logic accept;
    logic rd_fire;
    logic resp_valid_q;
    logic [WAYS*WIDTH-1:0] bank_rdata;
    logic [WAYS*WIDTH-1:0] rdata_hold_q;
    logic [AW-1:0] bank_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        io_req_ready = 1'b0;
        io_busy      = 1'b0;
        clr_active   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                io_busy    = 1'b1;
                clr_active = 1'b1;
                // DEPTH is a power of two, so the increment wraps to 0 on exit.
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                io_req_ready = !io_flush;
                if (io_flush) begin
                    state_d = ST_CLEAR;
                end
            end
        endcase
    end

    assign accept    = io_req_valid && io_req_ready;
    assign rd_fire   = accept && !io_req_wen;
    assign bank_addr = clr_active ? cnt_q : io_req_addr;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic             way_we;
        logic [WIDTH-1:0] way_wdata;

        assign way_we    = clr_active || (accept && io_req_wen && io_req_wmask[g]);
        assign way_wdata = clr_active ? '0 : io_req_wdata[way_lsb(g, WIDTH) +: WIDTH];

        bank_ram_1p #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_bank (
            .clock (clock),
            .we    (way_we),
            .re    (rd_fire),
            .addr  (bank_addr),
            .wdata (way_wdata),
            .rdata (bank_rdata[way_lsb(g, WIDTH) +: WIDTH])
        );
    end

    // The bank read register is unreset; the resettable hold copy covers
    // every cycle except the one where fresh data is presented.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            resp_valid_q <= rd_fire;
            if (resp_valid_q) begin
                rdata_hold_q <= bank_rdata;
            end
        end
    end

    assign io_resp_valid = resp_valid_q;
    assign io_resp_rdata = resp_valid_q ? bank_rdata : rdata_hold_q;

endmodule

// File: tb/tb_sram_array_1p_clr.sv
// Directed bench for sram_array_1p_clr with WAYS=2, DEPTH=64, WIDTH=66.
module tb_sram_array_1p_clr;

    localparam int WAYS  = 2;
    localparam int DEPTH = 64;
    localparam int WIDTH = 66;
    localparam int AW    = 6;

    localparam logic [WIDTH-1:0] W0 = 66'h3_FFFF_FFFF_FFFF_FFFF;
    localparam logic [WIDTH-1:0] W1 = 66'h1234;

    logic                  clock;
    logic                  reset;
    logic                  io_flush;
    logic                  io_req_valid;
    logic                  io_req_ready;
    logic [AW-1:0]         io_req_addr;
    logic                  io_req_wen;
    logic [WAYS-1:0]       io_req_wmask;
    logic [WAYS*WIDTH-1:0] io_req_wdata;
    logic                  io_resp_valid;
    logic [WAYS*WIDTH-1:0] io_resp_rdata;
    logic                  io_busy;

    int n_checks;
    int n_fail;

    sram_array_1p_clr #(
        .WAYS  (WAYS),
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_flush      (io_flush),
        .io_req_valid  (io_req_valid),
        .io_req_ready  (io_req_ready),
        .io_req_addr   (io_req_addr),
        .io_req_wen    (io_req_wen),
        .io_req_wmask  (io_req_wmask),
        .io_req_wdata  (io_req_wdata),
        .io_resp_valid (io_resp_valid),
        .io_resp_rdata (io_resp_rdata),
        .io_busy       (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        io_flush     = 1'b0;
        io_req_valid = 1'b0;
        io_req_wen   = 1'b0;
        io_req_addr  = '0;
        io_req_wmask = '0;
        io_req_wdata = '0;
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [WIDTH-1:0] d1,
                               input logic [WIDTH-1:0] d0, input logic [1:0] m);
        io_req_valid = 1'b1;
        io_req_wen   = 1'b1;
        io_req_addr  = a;
        io_req_wmask = m;
        io_req_wdata = {d1, d0};
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        int cycles;
        int ready_while_busy;
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if (io_req_ready !== 1'b0 || io_busy !== 1'b1 || io_resp_valid !== 1'b0 || io_resp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b busy=%b resp_valid=%b rdata=%h, required 0 1 0 0",
                     io_req_ready, io_busy, io_resp_valid, io_resp_rdata);
        end
        reset = 1'b1;
        cycles = 0;
        ready_while_busy = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cycles++;
            if (!io_busy) break;
            if (io_req_ready) ready_while_busy++;
        end
        n_checks++;
        if (cycles !== DEPTH) begin
            n_fail++;
            $display("FAIL reset_clear_len: busy cycles=%0d, required %0d", cycles, DEPTH);
        end
        n_checks++;
        if (io_req_ready !== 1'b1 || ready_while_busy !== 0) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b ready_while_busy=%0d, required 1 and 0",
                     io_req_ready, ready_while_busy);
        end
        for (int a = 0; a < DEPTH; a++) begin
            io_req_valid = 1'b1;
            io_req_wen   = 1'b0;
            io_req_addr  = AW'(a);
            tick();
            n_checks++;
            if (io_resp_valid !== 1'b1 || io_resp_rdata !== '0) begin
                n_fail++;
                $display("FAIL cleared_read[%0d]: valid=%b rdata=%h, required 1 and 0",
                         a, io_resp_valid, io_resp_rdata);
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if (io_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_valid_drop: valid=%b, required 0", io_resp_valid);
        end
    endtask

    task automatic test_masked_write();
        io_req_valid = 1'b1;
        io_req_wen   = 1'b1;
        io_req_addr  = 6'd5;
        io_req_wmask = 2'b01;
        io_req_wdata = {W1, W0};
        tick();
        n_checks++;
        if (io_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_resp: valid=%b, required 0", io_resp_valid);
        end
        io_req_wen = 1'b0;
        tick();
        idle_inputs();
        n_checks++;
        if (io_resp_valid !== 1'b1 || io_resp_rdata !== {66'h0, W0}) begin
            n_fail++;
            $display("FAIL masked_read: valid=%b rdata=%h, required 1 and %h",
                     io_resp_valid, io_resp_rdata, {66'h0, W0});
        end
        tick();
        n_checks++;
        if (io_resp_valid !== 1'b0 || io_resp_rdata !== {66'h0, W0}) begin
            n_fail++;
            $display("FAIL masked_hold: valid=%b rdata=%h, required 0 and %h",
                     io_resp_valid, io_resp_rdata, {66'h0, W0});
        end
    endtask

    task automatic test_back_to_back();
        logic [WAYS*WIDTH-1:0] exp [4];
        exp[1] = {66'h111, 66'h11};
        exp[2] = {66'h222, 66'h22};
        exp[3] = {66'h333, 66'h33};
        for (int a = 1; a <= 3; a++) begin
            write_entry(AW'(a), exp[a][WAYS*WIDTH-1:WIDTH], exp[a][WIDTH-1:0], 2'b11);
        end
        for (int a = 1; a <= 3; a++) begin
            io_req_valid = 1'b1;
            io_req_wen   = 1'b0;
            io_req_addr  = AW'(a);
            tick();
            n_checks++;
            if (io_resp_valid !== 1'b1 || io_resp_rdata !== exp[a]) begin
                n_fail++;
                $display("FAIL b2b_read[%0d]: valid=%b rdata=%h, required 1 and %h",
                         a, io_resp_valid, io_resp_rdata, exp[a]);
            end
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (io_resp_valid !== 1'b0 || io_resp_rdata !== exp[3]) begin
                n_fail++;
                $display("FAIL b2b_hold[%0d]: valid=%b rdata=%h, required 0 and %h",
                         i, io_resp_valid, io_resp_rdata, exp[3]);
            end
        end
        write_entry(6'd3, 66'h3A3A, 66'h5C5C, 2'b11);
        n_checks++;
        if (io_resp_valid !== 1'b0 || io_resp_rdata !== exp[3]) begin
            n_fail++;
            $display("FAIL hold_through_write: valid=%b rdata=%h, required 0 and %h",
                     io_resp_valid, io_resp_rdata, exp[3]);
        end
        io_req_valid = 1'b1;
        io_req_addr  = 6'd3;
        tick();
        idle_inputs();
        n_checks++;
        if (io_resp_valid !== 1'b1 || io_resp_rdata !== {66'h3A3A, 66'h5C5C}) begin
            n_fail++;
            $display("FAIL read_after_write: valid=%b rdata=%h, required 1 and %h",
                     io_resp_valid, io_resp_rdata, {66'h3A3A, 66'h5C5C});
        end
    endtask

    task automatic test_read_then_flush();
        int low;
        write_entry(6'd7, 66'h0, 66'hAB, 2'b11);
        io_req_valid = 1'b1;
        io_req_addr  = 6'd7;
        tick();
        idle_inputs();
        io_flush = 1'b1;
        #1;
        n_checks++;
        if (io_resp_valid !== 1'b1 || io_resp_rdata !== {66'h0, 66'hAB} || io_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_before_flush: valid=%b rdata=%h ready=%b, required 1 %h 0",
                     io_resp_valid, io_resp_rdata, io_req_ready, {66'h0, 66'hAB});
        end
        low = 1;
        tick();
        io_flush = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (io_req_ready) break;
            low++;
            tick();
        end
        n_checks++;
        if (low !== DEPTH + 1) begin
            n_fail++;
            $display("FAIL flush_ready_low: cycles=%0d, required %0d", low, DEPTH + 1);
        end
        n_checks++;
        if (io_resp_rdata !== {66'h0, 66'hAB}) begin
            n_fail++;
            $display("FAIL hold_through_clear: rdata=%h, required %h", io_resp_rdata, {66'h0, 66'hAB});
        end
        io_req_valid = 1'b1;
        io_req_addr  = 6'd7;
        tick();
        idle_inputs();
        n_checks++;
        if (io_resp_valid !== 1'b1 || io_resp_rdata !== '0) begin
            n_fail++;
            $display("FAIL read_after_flush: valid=%b rdata=%h, required 1 and 0",
                     io_resp_valid, io_resp_rdata);
        end
    endtask

    task automatic test_flush_with_req();
        int low;
        write_entry(6'd9, 66'h99, 66'h99, 2'b11);
        io_flush     = 1'b1;
        io_req_valid = 1'b1;
        io_req_wen   = 1'b0;
        io_req_addr  = 6'd9;
        #1;
        n_checks++;
        if (io_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_ready: ready=%b, required 0", io_req_ready);
        end
        low = 1;
        tick();
        idle_inputs();
        n_checks++;
        if (io_resp_valid !== 1'b0 || io_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_req_dropped: valid=%b busy=%b, required 0 and 1",
                     io_resp_valid, io_busy);
        end
        for (int i = 0; i < 200; i++) begin
            if (io_req_ready) break;
            low++;
            io_flush = (low == 20);
            tick();
        end
        io_flush = 1'b0;
        n_checks++;
        if (low !== DEPTH + 1) begin
            n_fail++;
            $display("FAIL flush_during_clear: cycles=%0d, required %0d", low, DEPTH + 1);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cycles;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        n_checks++;
        if (io_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_clear_busy: busy=%b, required 1", io_busy);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cycles++;
            if (!io_busy) break;
        end
        n_checks++;
        if (cycles !== DEPTH || io_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear_len: cycles=%0d ready=%b, required %0d and 1",
                     cycles, io_req_ready, DEPTH);
        end
    endtask

    task automatic test_reset_pending_read();
        write_entry(6'd7, 66'h55, 66'h55, 2'b11);
        io_req_valid = 1'b1;
        io_req_addr  = 6'd7;
        tick();
        n_checks++;
        if (io_resp_valid !== 1'b1 || io_resp_rdata !== {66'h55, 66'h55}) begin
            n_fail++;
            $display("FAIL pre_reset_read: valid=%b rdata=%h, required 1 and %h",
                     io_resp_valid, io_resp_rdata, {66'h55, 66'h55});
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        n_checks++;
        if (io_resp_valid !== 1'b0 || io_resp_rdata !== '0 || io_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_drops_resp: valid=%b rdata=%h busy=%b, required 0 0 1",
                     io_resp_valid, io_resp_rdata, io_busy);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!io_busy) break;
        end
        n_checks++;
        if (io_resp_valid !== 1'b0 || io_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle: valid=%b ready=%b, required 0 and 1",
                     io_resp_valid, io_req_ready);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_masked_write();
        test_back_to_back();
        test_read_then_flush();
        test_flush_with_req();
        test_reset_mid_clear();
        test_reset_pending_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_array_1p_clr.md
# sram_array_1p_clr

Parametrised single-port SRAM array for cache tag/data storage. It holds WAYS ways of WIDTH-bit words, DEPTH entries deep, behind a valid/ready request port, with per-way write mask and a one-cycle registered read response that holds its value. A built-in clear engine zeroes every entry after reset and on flush request, so that cache valid bits start clean without a software walk. It is the drop-in successor for the fixed single-way 64x66 array wrapper in the L1 cache datapath.

## Interface
- WAYS, 1, number of ways (independent banks sharing one address)
- DEPTH, 64, entries per way; power of two, at least 2
- WIDTH, 66, bits per way entry
- AW, log2(DEPTH), address width (derived, not overridable)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (array is reset when 0)
- io_flush  in  1  pulse: start a full clear pass
- io_req_valid  in  1  request present
- io_req_ready  out  1  request accepted when valid and ready are both 1
- io_req_addr  in  AW  entry index
- io_req_wen  in  1  1 = write, 0 = read
- io_req_wmask  in  WAYS  per-way write enable; ignored on reads
- io_req_wdata  in  WAYS*WIDTH  way i occupies bits [i*WIDTH +: WIDTH]
- io_resp_valid  out  1  read data valid this cycle
- io_resp_rdata  out  WAYS*WIDTH  read data, same packing as wdata
- io_busy  out  1  clear pass in progress

## Operation
- FSM states: CLEAR, IDLE. Reset forces CLEAR with clear counter 0.
- CLEAR: each cycle writes 0 to entry `cnt` of all ways and increments `cnt`. When `cnt` = DEPTH-1 is written, the next state is IDLE and `cnt` wraps to 0. io_busy = 1 and io_req_ready = 0 throughout.
- IDLE: io_req_ready = !io_flush. io_flush = 1 in IDLE moves to CLEAR next cycle; any io_req_valid in that cycle is not accepted.
- io_flush during CLEAR is ignored. The pass neither restarts nor extends.
- Accepted write: for each way i with wmask[i] = 1, the entry at addr is written with its wdata slice. Ways with wmask[i] = 0 are unchanged. No response is produced.
- Accepted write with wmask all 0 is legal and has no effect.
- Accepted read: all ways are read at addr. io_resp_valid = 1 for exactly the following cycle.
- io_resp_rdata is held from a registered copy until the next read response. Writes, flushes and clears do not alter it.
- Read issued the cycle before a flush is taken still returns its (pre-clear) data on the next cycle.
- Back-to-back reads are accepted every cycle, giving one response per cycle.
- A read following a write to the same address returns the new data.
- Reset asserted mid-CLEAR or mid-read restarts the clear pass from entry 0 and drops any pending response.

## Timing
- Reset values: io_req_ready 0, io_busy 1, io_resp_valid 0, io_resp_rdata 0.
- After reset deasserts, clear takes DEPTH cycles. io_req_ready first rises DEPTH cycles after the first rising edge with reset high.
- Read latency is 1 cycle, from the accept edge to io_resp_valid.
- Write takes effect at the accept edge.
- Flush-to-ready is DEPTH+1 cycles: 1 cycle to enter CLEAR, then DEPTH cycles of clearing.
- io_req_ready depends combinationally only on state and io_flush, never on io_req_valid.

## Structure
- Shared cache package holds:
  - the FSM state encoding (CLEAR=0, IDLE=1)
  - the log2 helper used for AW
  - the WAYS*WIDTH packing convention
- One sub-module, bank_ram_1p, instantiated WAYS times:
  - synchronous single-port memory with one-cycle read latency
  - write enable input; no reset on its contents
- The array muxes address and write data between the clear counter and the request port.
- Per-way write enable = CLEAR ? 1 : (accept & wen & wmask[i]).

## Test plan
- Reset release with DEPTH=64, WAYS=2: io_busy high for exactly 64 cycles, ready rises on cycle 64, then a read of every address returns 0.
- Write addr 5 wdata way0=0x3_FFFF_FFFF_FFFF_FFFF, way1=0x1234, wmask=2'b01; then read addr 5 -> resp way0=0x3_FFFF_FFFF_FFFF_FFFF, way1=0, valid one cycle later.
- Back-to-back reads of addr 1, 2, 3 -> three consecutive resp_valid cycles in order. rdata then holds addr-3 data for 10 idle cycles and through an intervening write.
- Read addr 7 (holding 0xAB), then flush on the next cycle -> response 0xAB arrives, ready stays low for 65 cycles, and a later read of addr 7 returns 0.
- Flush with req_valid in the same IDLE cycle -> request not accepted. Flush pulsed again during CLEAR -> ready returns on the original schedule.
- Reset asserted at clear count 30 and released -> clear restarts from 0 and takes a full 64 cycles. Reset during a pending read -> no resp_valid.
